// File: rtl/i2s_tx_if.sv
// Sample input stream for the I2S transmitter.
// Handshake: the source holds InputData stable while InputValid is high. A word
// transfers on a rising MasterCLK edge where InputValid && InputReady are both 1.
// InputReady does not depend on InputValid in the same cycle.
interface i2s_tx_if;
  logic [31:0] InputData;
  logic        InputValid;
  logic        InputReady;

  modport master (output InputData, output InputValid, input InputReady);
  modport slave  (input InputData, input InputValid, output InputReady);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: 4-deep sample FIFO feeding a 32-bit frame shifter.
// The bit clock is divided from MasterCLK. WS and DATA change on the falling
// bit-clock toggle. The first data bit follows the WS edge by one bit.
module i2s_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       MasterCLK,
  input  logic       Reset,
  i2s_tx_if.slave    in_if,
  output logic       SyncCLK,
  output logic       Underrun,
  output logic       I2S_CLK,
  output logic       I2S_WS,
  output logic       I2S_DATA,
  output logic [4:0] dbg_bit_cnt
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] frame;
  logic [31:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  logic        tick;
  logic        fall;
  logic        load;
  logic        push;
  logic        pop;
  logic [4:0]  bit_next;
  logic [4:0]  data_idx;

  assign tick     = (div_cnt == DIV_LAST);
  assign fall     = tick && I2S_CLK;
  assign bit_next = bit_cnt + 5'd1;
  assign load     = fall && (bit_next == 5'd0);
  // Bit 32-n of the current frame; at n=0 this wraps to bit 0 of the old frame.
  assign data_idx = 5'd0 - bit_next;

  assign in_if.InputReady = (count < 3'd4);
  assign push             = in_if.InputValid && in_if.InputReady;
  // No bypass: a word pushed into an empty FIFO is not visible to this pop.
  assign pop              = load && (count != 3'd0);
  assign dbg_bit_cnt      = bit_cnt;

  // Clock divider and bit clock generation.
  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      div_cnt <= 8'd0;
      I2S_CLK <= 1'b0;
    end else if (tick) begin
      div_cnt <= 8'd0;
      I2S_CLK <= ~I2S_CLK;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Bit counter, serial outputs and frame load on the falling bit-clock toggle.
  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      bit_cnt  <= 5'd31;
      frame    <= 32'h0;
      I2S_WS   <= 1'b0;
      I2S_DATA <= 1'b0;
      SyncCLK  <= 1'b0;
    end else begin
      SyncCLK <= load;
      if (fall) begin
        bit_cnt  <= bit_next;
        I2S_WS   <= bit_next[4];
        I2S_DATA <= frame[data_idx];
        if (load) begin
          frame <= (count != 3'd0) ? fifo_mem[rd_ptr] : 32'h0;
        end
      end
    end
  end

  // Sample FIFO storage and occupancy.
  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= in_if.InputData;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky underrun: a frame was loaded while the FIFO was empty.
  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      Underrun <= 1'b0;
    end else if (load && (count == 3'd0)) begin
      Underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a CLK_DIV=2 instance checked every cycle against a
// time-based reference model, plus a CLK_DIV=1 instance with continuous supply.
module tb_i2s_tx;

  localparam int DIV = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_tx_if bus ();
  i2s_tx_if bus1 ();

  logic       sync, under, sclk, ws, sdata;
  logic [4:0] dbg;
  logic       sync1, under1, sclk1, ws1, sdata1;
  logic [4:0] dbg1;

  i2s_tx #(.CLK_DIV(DIV)) dut (
    .MasterCLK(clk), .Reset(rst), .in_if(bus),
    .SyncCLK(sync), .Underrun(under), .I2S_CLK(sclk),
    .I2S_WS(ws), .I2S_DATA(sdata), .dbg_bit_cnt(dbg)
  );

  i2s_tx #(.CLK_DIV(1)) dut1 (
    .MasterCLK(clk), .Reset(rst), .in_if(bus1),
    .SyncCLK(sync1), .Underrun(under1), .I2S_CLK(sclk1),
    .I2S_WS(ws1), .I2S_DATA(sdata1), .dbg_bit_cnt(dbg1)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Timing follows from the edge count t since reset release: the bit clock
  // is (t/DIV)%2 and falling toggle m happens at t = 2*DIV*m with n = (m-1)%32.
  logic [31:0] exp_q[$];
  logic [31:0] m_frame = 32'h0;
  int          t = 0;
  int          m_n = 31;
  logic        e_clk = 0, e_ws = 0, e_data = 0, e_sync = 0, e_under = 0;
  int          cnt_before;
  bit          accept;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; exp_q.delete(); m_frame = 32'h0; m_n = 31;
      e_clk = 0; e_ws = 0; e_data = 0; e_sync = 0; e_under = 0;
    end else begin
      cnt_before = exp_q.size();
      accept     = bus.InputValid && (cnt_before < 4);
      t++;
      e_clk  = ((t / DIV) % 2) == 1;
      e_sync = 0;
      if (t % (2 * DIV) == 0) begin
        m_n    = ((t / (2 * DIV)) - 1) % 32;
        e_ws   = (m_n >= 16);
        e_data = m_frame[(32 - m_n) % 32];
        if (m_n == 0) begin
          e_sync = 1;
          if (cnt_before > 0) m_frame = exp_q.pop_front();
          else begin
            m_frame = 32'h0;
            e_under = 1;
          end
        end
      end
      if (accept) exp_q.push_back(bus.InputData);
    end
  end

  always @(negedge clk) begin
    check("i2s_clk", 32'(sclk), 32'(e_clk));
    check("i2s_ws", 32'(ws), 32'(e_ws));
    check("i2s_data", 32'(sdata), 32'(e_data));
    check("sync", 32'(sync), 32'(e_sync));
    check("underrun", 32'(under), 32'(e_under));
    check("ready", 32'(bus.InputReady), 32'(exp_q.size() < 4));
    check("bit_cnt", 32'(dbg), 32'(m_n));
  end

  // ---------------- CLK_DIV=1 instance: continuous supply ----------------
  int c1 = 0;
  int nsync1 = 0;
  always @(posedge clk) begin
    if (rst) c1 = 0;
    else c1++;
  end

  always @(negedge clk) begin
    bus1.InputValid = 1'b1;
    bus1.InputData  = $urandom;
    if (!rst && c1 >= 1) begin
      check("clk1_toggle", 32'(sclk1), 32'(c1 % 2));
      check("under1", 32'(under1), 32'd0);
      if (sync1) begin
        nsync1++;
        check("sync1_phase", 32'(c1 % 64), 32'd2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.InputValid = 1'b0;
    idle(n);
    rst = 1'b0;
  endtask

  task automatic push_burst(input int n);
    for (int i = 0; i < n; i++) begin
      bus.InputValid = 1'b1;
      bus.InputData  = $urandom;
      @(negedge clk);
    end
    bus.InputValid = 1'b0;
  endtask

  task automatic random_traffic(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.InputValid = ($urandom_range(0, 3) == 0);
      bus.InputData  = $urandom;
      @(negedge clk);
    end
    bus.InputValid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    bus.InputValid = 1'b0;
    bus.InputData  = 32'h0;

    // Reset held 3 cycles.
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_ws", 32'(ws), 32'd0);
    check("rst_data", 32'(sdata), 32'd0);
    check("rst_sync", 32'(sync), 32'd0);
    check("rst_under", 32'(under), 32'd0);
    check("rst_ready", 32'(bus.InputReady), 32'd1);

    // Single known frame pushed before the first load.
    rst = 1'b0;
    bus.InputValid = 1'b1;
    bus.InputData  = 32'hA5A5_0F0F;
    @(negedge clk);
    bus.InputValid = 1'b0;
    idle(3);
    check("sync_at_4", 32'(sync), 32'd1);
    check("under_first", 32'(under), 32'd0);
    idle(130);

    // Five back-to-back pushes with no load in between.
    do_reset(3);
    idle(6);
    push_burst(5);
    check("ready_full", 32'(bus.InputReady), 32'd0);
    idle(6 * 64 * DIV);

    // No pushes: zero frame and sticky underrun.
    do_reset(3);
    idle(64 * DIV + 4);
    check("under_set", 32'(under), 32'd1);
    push_burst(3);
    idle(2 * 64 * DIV);
    check("under_sticky", 32'(under), 32'd1);

    // Reset pulsed mid-frame at n=20.
    do_reset(3);
    random_traffic(40);
    begin
      int k = 0;
      while (m_n != 20 && k < 400) begin
        @(negedge clk);
        k++;
      end
      check("wait_n20", 32'(m_n == 20), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 32'(bus.InputReady), 32'd1);
    check("mid_rst_cnt", 32'(dbg), 32'd31);
    random_traffic(4 * 64 * DIV);

    // Long randomized run.
    random_traffic(8 * 64 * DIV);
    idle(64 * DIV);

    check("sync1_seen", 32'(nsync1 > 10), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
